eachseq: RTL

Channel enable sequencer for the EA4163 interface. Takes host command writes at 0x7C94 (channel enable) and 0x7CA6 (restart), buffers one command, and drives `eareset`, `inchen` and `outchen` in a fixed safe order: reset pulse and settle on first use, then one channel change per step with a guard gap. It sits between the host bus decode and the EA channel datapath.

---
 rtl/eachseq.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eachseq.sv
// rtl/eachseq.sv - EA4163 channel enable sequencer; optional watchdog under EACHSEQ_WDOG_EN
module eachseq #(
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int WDOG_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] cmd,
  output logic        ready,
  output logic        busy,
  output logic        eareset,
  output logic        inchen,
  output logic        outchen,
  output logic        err,
  output logic        wdog
);

  localparam int MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAX_C = (MAX_B > WDOG_CYCLES) ? MAX_B : WDOG_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [15:0]   ADDR_CHEN   = 16'h7C94;
  localparam logic [15:0]   ADDR_RST    = 16'h7CA6;
  localparam logic [CW-1:0] RESET_LOAD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RST_PULSE = 2'd1,
    S_SETTLE    = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend_v, pend_v_n;
  logic [15:0]   pend_addr, pend_addr_n;
  logic [15:0]   pend_cmd, pend_cmd_n;
  logic          tgt_in, tgt_in_n;
  logic          tgt_out, tgt_out_n;
  logic          init, init_n;
  logic          restart, restart_n;
  logic          eareset_n, inchen_n, outchen_n, err_n;
  logic          pop, accept;

`ifdef EACHSEQ_WDOG_EN
  logic [CW-1:0] wcnt, wcnt_n;
  logic          wdog_q, wdog_n;
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);
`endif

  // A popped slot frees on the same edge, so a write landing on a pop edge is taken.
  assign pop    = (state == S_IDLE) && pend_v;
  assign accept = wr && (!pend_v || pop);
  assign ready  = ~pend_v;
  assign busy   = (state != S_IDLE) || pend_v;

  // Next-state, command decode and channel step selection.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pend_v_n    = pend_v;
    pend_addr_n = pend_addr;
    pend_cmd_n  = pend_cmd;
    tgt_in_n    = tgt_in;
    tgt_out_n   = tgt_out;
    init_n      = init;
    restart_n   = restart;
    eareset_n   = eareset;
    inchen_n    = inchen;
    outchen_n   = outchen;
    err_n       = err;
`ifdef EACHSEQ_WDOG_EN
    wcnt_n      = wcnt;
    wdog_n      = wdog_q;
`endif

    case (state)
      S_IDLE: begin
        if (pop) begin
          // Decode cycle: only targets/flags move, channel outputs hold.
          pend_v_n = 1'b0;
          if (pend_addr == ADDR_CHEN) begin
            case (pend_cmd)
              16'h0001: tgt_out_n = 1'b1;
              16'h0010: tgt_out_n = 1'b0;
              16'h0002: tgt_in_n  = 1'b1;
              16'h0020: tgt_in_n  = 1'b0;
              16'h0003: begin
                tgt_in_n  = 1'b1;
                tgt_out_n = 1'b1;
              end
              16'h0030: begin
                tgt_in_n  = 1'b0;
                tgt_out_n = 1'b0;
              end
              default:  err_n = 1'b1;
            endcase
          end else if ((pend_addr == ADDR_RST) && (pend_cmd == 16'h0001)) begin
            restart_n = 1'b1;
            err_n     = 1'b0;
`ifdef EACHSEQ_WDOG_EN
            wdog_n    = 1'b0;
`endif
          end else begin
            err_n = 1'b1;
          end
        end else if (restart || (!init && (tgt_in || tgt_out))) begin
          state_n   = S_RST_PULSE;
          cnt_n     = RESET_LOAD;
          eareset_n = 1'b1;
          inchen_n  = 1'b0;
          outchen_n = 1'b0;
          restart_n = 1'b0;
        end else if (outchen && !tgt_out) begin
          outchen_n = 1'b0;
          state_n   = S_GAP;
          cnt_n     = GAP_LOAD;
        end else if (inchen && !tgt_in) begin
          inchen_n  = 1'b0;
          state_n   = S_GAP;
          cnt_n     = GAP_LOAD;
        end else if (tgt_in && !inchen) begin
          inchen_n  = 1'b1;
          state_n   = S_GAP;
          cnt_n     = GAP_LOAD;
        end else if (tgt_out && !outchen) begin
          outchen_n = 1'b1;
          state_n   = S_GAP;
          cnt_n     = GAP_LOAD;
        end
      end
      S_RST_PULSE: begin
        if (cnt == '0) begin
          state_n   = S_SETTLE;
          cnt_n     = SETTLE_LOAD;
          eareset_n = 1'b0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          init_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      pend_v_n    = 1'b1;
      pend_addr_n = addr;
      pend_cmd_n  = cmd;
    end else if (wr) begin
      err_n = 1'b1;
    end

`ifdef EACHSEQ_WDOG_EN
    // Host silence while a channel is wanted: drop targets, disable runs the normal order.
    if (accept) begin
      wcnt_n = '0;
    end else if (tgt_in || tgt_out) begin
      if (wcnt == WDOG_LAST) begin
        wcnt_n    = '0;
        tgt_in_n  = 1'b0;
        tgt_out_n = 1'b0;
        wdog_n    = 1'b1;
      end else begin
        wcnt_n = wcnt + CNT_ONE;
      end
    end else begin
      wcnt_n = '0;
    end
`endif
  end

  // State and datapath registers; reset returns to a cold, uninitialised sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_cmd  <= '0;
      tgt_in    <= 1'b0;
      tgt_out   <= 1'b0;
      init      <= 1'b0;
      restart   <= 1'b0;
      eareset   <= 1'b0;
      inchen    <= 1'b0;
      outchen   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend_v    <= pend_v_n;
      pend_addr <= pend_addr_n;
      pend_cmd  <= pend_cmd_n;
      tgt_in    <= tgt_in_n;
      tgt_out   <= tgt_out_n;
      init      <= init_n;
      restart   <= restart_n;
      eareset   <= eareset_n;
      inchen    <= inchen_n;
      outchen   <= outchen_n;
      err       <= err_n;
    end
  end

`ifdef EACHSEQ_WDOG_EN
  // Watchdog counter and sticky trip flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt   <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt   <= wcnt_n;
      wdog_q <= wdog_n;
    end
  end

  assign wdog = wdog_q;
`else
  assign wdog = 1'b0;
`endif

endmodule
